// File: rtl/seg_scan_rx_pkg.sv
// Shared constants and types for the 6-digit 7-segment scan link.
// The encoder side uses the same segment patterns.
package seg_scan_rx_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int DIGITS_W   = 4 * NUM_DIGITS;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_PAT_0 = 7'b1000000;
    localparam logic [6:0] SEG_PAT_1 = 7'b1111001;
    localparam logic [6:0] SEG_PAT_2 = 7'b0100100;
    localparam logic [6:0] SEG_PAT_3 = 7'b0110000;
    localparam logic [6:0] SEG_PAT_4 = 7'b0011001;
    localparam logic [6:0] SEG_PAT_5 = 7'b0010010;
    localparam logic [6:0] SEG_PAT_6 = 7'b0000010;
    localparam logic [6:0] SEG_PAT_7 = 7'b1111000;
    localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
    localparam logic [6:0] SEG_PAT_9 = 7'b0010000;
    localparam logic [6:0] SEG_PAT_A = 7'b0001000;
    localparam logic [6:0] SEG_PAT_B = 7'b0000011;
    localparam logic [6:0] SEG_PAT_C = 7'b1000110;
    localparam logic [6:0] SEG_PAT_D = 7'b0100001;
    localparam logic [6:0] SEG_PAT_E = 7'b0000110;
    localparam logic [6:0] SEG_PAT_F = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } scan_state_e;

    // A select is usable only when exactly one active-low line is asserted.
    function automatic logic sel_is_valid(input logic [NUM_DIGITS-1:0] sel_n);
        int lows;
        lows = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_n[i]) lows++;
        end
        return (lows == 1);
    endfunction

    function automatic logic [IDX_W-1:0] sel_index(input logic [NUM_DIGITS-1:0] sel_n);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!sel_n[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0: pat = SEG_PAT_0;
            4'h1: pat = SEG_PAT_1;
            4'h2: pat = SEG_PAT_2;
            4'h3: pat = SEG_PAT_3;
            4'h4: pat = SEG_PAT_4;
            4'h5: pat = SEG_PAT_5;
            4'h6: pat = SEG_PAT_6;
            4'h7: pat = SEG_PAT_7;
            4'h8: pat = SEG_PAT_8;
            4'h9: pat = SEG_PAT_9;
            4'hA: pat = SEG_PAT_A;
            4'hB: pat = SEG_PAT_B;
            4'hC: pat = SEG_PAT_C;
            4'hD: pat = SEG_PAT_D;
            4'hE: pat = SEG_PAT_E;
            default: pat = SEG_PAT_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_rx_if.sv
// Scan-side inputs and decoded-frame outputs of the segment receiver.
// The scan driver (or bench) is the master; the receiver is the slave.
interface seg_scan_rx_if;
    import seg_scan_rx_pkg::*;

    logic [NUM_DIGITS-1:0] seg_sel_in;
    logic [7:0]            seg_data_in;
    logic [DIGITS_W-1:0]   digits;
    logic [NUM_DIGITS-1:0] dp_flags;
    logic                  frame_valid;
    logic                  pattern_err;
    logic                  link_ok;

    modport master (
        output seg_sel_in, seg_data_in,
        input  digits, dp_flags, frame_valid, pattern_err, link_ok
    );

    modport slave (
        input  seg_sel_in, seg_data_in,
        output digits, dp_flags, frame_valid, pattern_err, link_ok
    );

endinterface

// File: rtl/seg_pattern_decoder.sv
// Combinational 7-segment pattern to hex code decoder.
// Unknown patterns (including blank) give code 0 with valid low.
module seg_pattern_decoder
    import seg_scan_rx_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       valid,
    output logic [3:0] code
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        valid = 1'b1;
        code  = 4'h0;
        case (seg_n)
            SEG_PAT_0: code = 4'h0;
            SEG_PAT_1: code = 4'h1;
            SEG_PAT_2: code = 4'h2;
            SEG_PAT_3: code = 4'h3;
            SEG_PAT_4: code = 4'h4;
            SEG_PAT_5: code = 4'h5;
            SEG_PAT_6: code = 4'h6;
            SEG_PAT_7: code = 4'h7;
            SEG_PAT_8: code = 4'h8;
            SEG_PAT_9: code = 4'h9;
            SEG_PAT_A: code = 4'hA;
            SEG_PAT_B: code = 4'hB;
            SEG_PAT_C: code = 4'hC;
            SEG_PAT_D: code = 4'hD;
            SEG_PAT_E: code = 4'hE;
            SEG_PAT_F: code = 4'hF;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// Receiver for a multiplexed 6-digit 7-segment scan: de-ghosts each digit window,
// decodes it, and publishes complete frames with a link-alive timeout.
module seg_scan_rx
    import seg_scan_rx_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_200_000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_rx_if.slave  bus
);

    localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [23:0]      TMO_LIMIT   = 24'(TIMEOUT_CYCLES);

    logic [NUM_DIGITS-1:0] sel_meta, sel_s, sel_q;
    logic [7:0]            data_meta, data_s;

    scan_state_e           state, state_next;
    logic [CNT_W-1:0]      settle_cnt;
    logic                  cnt_clr, cnt_inc, do_sample;
    logic                  sel_valid, sel_changed;
    logic [IDX_W-1:0]      sel_idx;

    logic                  dec_valid;
    logic [3:0]            dec_code;

    logic [3:0]            slot_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] slot_dp;
    logic [NUM_DIGITS-1:0] captured, cap_next;
    logic                  frame_done;
    logic [DIGITS_W-1:0]   frame_digits;

    logic [DIGITS_W-1:0]   digits_q;
    logic [NUM_DIGITS-1:0] dp_flags_q;
    logic                  frame_valid_q;
    logic                  link_ok_q;
    logic [23:0]           tmo_cnt;

    // Two-stage synchronizer; idle value is all-high (nothing selected, segments dark).
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_meta  <= '1;
            sel_s     <= '1;
            sel_q     <= '1;
            data_meta <= '1;
            data_s    <= '1;
        end else begin
            sel_meta  <= bus.seg_sel_in;
            sel_s     <= sel_meta;
            sel_q     <= sel_s;
            data_meta <= bus.seg_data_in;
            data_s    <= data_meta;
        end
    end

    assign sel_valid   = sel_is_valid(sel_s);
    assign sel_changed = (sel_s != sel_q);
    assign sel_idx     = sel_index(sel_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WAIT;
            settle_cnt <= '0;
        end else begin
            state <= state_next;
            if (cnt_clr)      settle_cnt <= '0;
            else if (cnt_inc) settle_cnt <= settle_cnt + 1'b1;
        end
    end

    // The sample is taken only if the select is still the same one it settled on.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        do_sample  = 1'b0;
        case (state)
            ST_WAIT: begin
                if (sel_valid) begin
                    state_next = ST_SETTLE;
                    cnt_clr    = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!sel_valid)                 state_next = ST_WAIT;
                else if (sel_changed)           cnt_clr    = 1'b1;
                else if (settle_cnt == SETTLE_LAST) state_next = ST_SAMPLE;
                else                            cnt_inc    = 1'b1;
            end
            ST_SAMPLE: begin
                if (!sel_valid) begin
                    state_next = ST_WAIT;
                end else if (sel_changed) begin
                    state_next = ST_SETTLE;
                    cnt_clr    = 1'b1;
                end else begin
                    do_sample  = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!sel_valid) begin
                    state_next = ST_WAIT;
                end else if (sel_changed) begin
                    state_next = ST_SETTLE;
                    cnt_clr    = 1'b1;
                end
            end
            default: state_next = ST_WAIT;
        endcase
    end

    seg_pattern_decoder u_decoder (
        .seg_n (data_s[6:0]),
        .valid (dec_valid),
        .code  (dec_code)
    );

    assign frame_done = &captured;

    // A sample landing in the frame-complete cycle starts the next frame.
    always_comb begin
        cap_next = frame_done ? '0 : captured;
        if (do_sample) cap_next[sel_idx] = 1'b1;
    end

    always_comb begin
        frame_digits = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            frame_digits[(NUM_DIGITS-1-i)*4 +: 4] = slot_code[i];
        end
    end

    // NOTE: the slot array is a handful of flops, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) slot_code[i] <= '0;
            slot_dp  <= '0;
            captured <= '0;
        end else begin
            captured <= cap_next;
            if (do_sample) begin
                slot_code[sel_idx] <= dec_code;
                slot_dp[sel_idx]   <= ~data_s[7];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q      <= '0;
            dp_flags_q    <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= frame_done;
            if (frame_done) begin
                digits_q   <= frame_digits;
                dp_flags_q <= slot_dp;
            end
        end
    end

    // Link watchdog: restarted by every published frame, saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            link_ok_q <= 1'b0;
        end else if (frame_done) begin
            tmo_cnt   <= '0;
            link_ok_q <= 1'b1;
        end else if (tmo_cnt != TMO_LIMIT) begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (tmo_cnt + 24'd1 == TMO_LIMIT) link_ok_q <= 1'b0;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.dp_flags    = dp_flags_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.pattern_err = do_sample & ~dec_valid;
    assign bus.link_ok     = link_ok_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Scoreboard bench for seg_scan_rx: a slot/captured-set model predicts frames,
// a negedge monitor pops and compares whenever frame_valid is seen.
module tb_seg_scan_rx;

    localparam int SETTLE = 16;
    localparam int TMO    = 3000;
    localparam int DWELL  = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_rx_if bus ();

    seg_scan_rx #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] hex_pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_seen = 0;
    int exp_err  = 0;
    int last_fv_cyc = -1;
    int fall_cyc    = -1;
    bit link_prev   = 1'b0;
    logic [29:0] exp_q [$];

    int m_code [6];
    bit m_dp   [6];
    bit m_cap  [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [29:0] e;
        if (rst_n) begin
            if (bus.pattern_err === 1'b1) err_seen++;
            if (bus.frame_valid === 1'b1) begin
                last_fv_cyc = cyc;
                check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("digits", 32'(bus.digits), 32'(e[29:6]));
                    check("dp_flags", 32'(bus.dp_flags), 32'(e[5:0]));
                end
                check("link_ok_on_frame", 32'(bus.link_ok), 32'd1);
            end
            if (link_prev && !bus.link_ok) fall_cyc = cyc;
        end
        link_prev = bus.link_ok;
    end

    function automatic int decode_pat(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (hex_pat[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_code[i] = 0;
            m_dp[i]   = 1'b0;
            m_cap[i]  = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_sample(input int idx, input logic [6:0] pat, input bit dp);
        int c;
        bit all;
        logic [23:0] d;
        logic [5:0]  f;
        c = decode_pat(pat);
        if (c < 0) begin
            exp_err++;
            c = 0;
        end
        m_code[idx] = c;
        m_dp[idx]   = dp;
        m_cap[idx]  = 1'b1;
        all = 1'b1;
        for (int i = 0; i < 6; i++) all &= m_cap[i];
        if (all) begin
            for (int i = 0; i < 6; i++) begin
                d[23-4*i -: 4] = m_code[i][3:0];
                f[i]           = m_dp[i];
                m_cap[i]       = 1'b0;
            end
            exp_q.push_back({d, f});
        end
    endtask

    // Called #1 after a rising edge; leaves time at #1 after a rising edge.
    task automatic drive_digit(input int idx, input logic [6:0] pat, input bit dp,
                               input int hold, input int ghost_n, input logic [7:0] ghost);
        if (hold >= SETTLE + 8) model_sample(idx, pat, dp);
        bus.seg_sel_in = ~(6'd1 << idx);
        for (int k = 0; k < hold; k++) begin
            bus.seg_data_in = (k < ghost_n) ? ghost : {~dp, pat};
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n, input logic [5:0] sel);
        bus.seg_sel_in  = sel;
        bus.seg_data_in = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_range(input logic [23:0] val, input logic [5:0] dp, input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            drive_digit(i, hex_pat[val[23-4*i -: 4]], dp[i], DWELL, 0, 8'hFF);
    endtask

    task automatic drain(input string name);
        idle(60, 6'h3F);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_pattern_err_count"}, 32'(err_seen), 32'(exp_err));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ord [6];
        logic [6:0] prev_pat;
        bus.seg_sel_in  = 6'h3F;
        bus.seg_data_in = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", 32'(bus.digits), 32'd0);
        check("rst_dp_flags", 32'(bus.dp_flags), 32'd0);
        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_pattern_err", 32'(bus.pattern_err), 32'd0);
        check("rst_link_ok", 32'(bus.link_ok), 32'd0);
        rst_n = 1'b1;
        idle(5, 6'h3F);

        // Plain scans of "123456"
        check("link_before_first", 32'(bus.link_ok), 32'd0);
        scan_range(24'h123456, 6'b0, 0, 5);
        check("link_after_first", 32'(bus.link_ok), 32'd1);
        scan_range(24'h123456, 6'b0, 0, 5);
        drain("scan123456");

        // Ghosting: data lags the select change by 5 cycles
        prev_pat = 7'h7F;
        for (int i = 0; i < 6; i++) begin
            drive_digit(i, hex_pat[i + 7], 1'b0, DWELL, 5, {1'b1, prev_pat});
            prev_pat = hex_pat[i + 7];
        end
        drain("ghost");
        // Digit 0 held one cycle short of settling must not be captured
        drive_digit(0, hex_pat[9], 1'b0, SETTLE - 1, 0, 8'hFF);
        idle(5, 6'h3F);
        scan_range(24'h0ABCDE, 6'b0, 1, 5);
        drain("short_hold");
        drive_digit(0, hex_pat[4], 1'b0, DWELL, 0, 8'hFF);
        drain("short_hold_complete");

        // Bad pattern on digit 2, dp on digit 3, two scans
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 6; i++)
                drive_digit(i, (i == 2) ? 7'b1010101 : hex_pat[i + 1], (i == 3), DWELL, 0, 8'hFF);
        end
        drain("pattern_err");
        check("perr_digits", 32'(bus.digits), 32'h120456);
        check("perr_dp_flags", 32'(bus.dp_flags), 32'b001000);

        // Idle/invalid selects in the middle of a frame keep the captured set
        scan_range(24'h654321, 6'b000101, 0, 2);
        idle(2000, 6'h3F);
        idle(2000, 6'b110011);
        check("idle_pattern_err_count", 32'(err_seen), 32'(exp_err));
        check("idle_digits_held", 32'(bus.digits), 32'h120456);
        check("idle_link_dropped", 32'(bus.link_ok), 32'd0);
        scan_range(24'h654321, 6'b000101, 3, 5);
        drain("idle");

        // Re-capture before completion: latest value wins
        scan_range(24'h13579B, 6'b0, 0, 2);
        drive_digit(1, hex_pat[14], 1'b1, DWELL, 0, 8'hFF);
        scan_range(24'h13579B, 6'b0, 3, 5);
        drain("overwrite");

        // Timeout after scanning stops, then recovery
        fall_cyc = -1;
        scan_range(24'h123456, 6'b0, 0, 5);
        idle(1, 6'h3F);
        for (int k = 0; k < TMO + 200 && fall_cyc < 0; k++) idle(1, 6'h3F);
        check("timeout_seen", 32'(fall_cyc >= 0), 32'd1);
        check("timeout_length", 32'(fall_cyc - last_fv_cyc), 32'(TMO));
        check("timeout_link_ok", 32'(bus.link_ok), 32'd0);
        check("timeout_digits_held", 32'(bus.digits), 32'h123456);
        scan_range(24'hABCDEF, 6'b100001, 0, 5);
        drain("resume");
        check("resume_link_ok", 32'(bus.link_ok), 32'd1);

        // Reset after three digits discards the partial frame
        scan_range(24'h777777, 6'b0, 0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_digits", 32'(bus.digits), 32'd0);
        check("midrst_dp_flags", 32'(bus.dp_flags), 32'd0);
        check("midrst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("midrst_pattern_err", 32'(bus.pattern_err), 32'd0);
        check("midrst_link_ok", 32'(bus.link_ok), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5, 6'h3F);
        scan_range(24'h246813, 6'b0, 3, 5);
        drain("after_rst_partial");
        scan_range(24'h246813, 6'b0, 0, 2);
        drain("after_rst_full");

        // Randomized scans: random order, values, dp, ghosts and odd patterns
        for (int s = 0; s < 15; s++) begin
            for (int i = 0; i < 6; i++) ord[i] = i;
            for (int i = 5; i > 0; i--) begin
                int j;
                int t;
                j = int'($urandom_range(i, 0));
                t = ord[i];
                ord[i] = ord[j];
                ord[j] = t;
            end
            for (int i = 0; i < 6; i++) begin
                logic [6:0] pat;
                if ($urandom_range(4, 0) == 0) pat = 7'($urandom_range(127, 0));
                else                           pat = hex_pat[$urandom_range(15, 0)];
                drive_digit(ord[i], pat, 1'($urandom_range(1, 0)), DWELL,
                            int'($urandom_range(8, 0)), 8'($urandom_range(255, 0)));
            end
            idle(3, 6'h3F);
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
